dut_core: RTL and testbench



---
 rtl/dut_pkg.sv | 10 +
 rtl/dut_pipe_stage.sv | 30 +++
 rtl/dut_core.sv | 88 ++++++++
 tb/tb_dut_core.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_pkg.sv
// Shared widths, sample/result types and the saturation limit for the squaring pipeline.
package dut_pkg;
  localparam int DATAW = 16;
  localparam int RESW  = 2 * DATAW;

  typedef logic signed [DATAW-1:0] sample_t;
  typedef logic signed [RESW-1:0]  result_t;

  localparam result_t RESULT_MAX = {1'b0, {(RESW-1){1'b1}}};
endpackage

// File: rtl/dut_pipe_stage.sv
// One elastic valid/ready register stage; accepts whenever empty or draining this cycle.
module dut_pipe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) data_reg <= in_data;
    end
  end
endmodule

// File: rtl/dut_core.sv
// Streaming signed squarer: STAGES elastic stages (square formed ahead of stage 0) then an output register.
// Optional running saturating accumulation of squares: define DUT_ACCUM_EN.
module dut_core #(
  parameter int DATAW  = dut_pkg::DATAW,
  parameter int STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATAW-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*DATAW-1:0] out_data
);
  import dut_pkg::*;

  localparam int RW = 2 * DATAW;

  logic          v   [0:STAGES];
  logic          rdy [0:STAGES];
  logic [RW-1:0] d   [0:STAGES];

  // Sign-extend first so the truncated product equals the full-precision square.
  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] sq;
  assign ext = {{DATAW{in_data[DATAW-1]}}, in_data};
  assign sq  = ext * ext;

  assign v[0]     = in_valid;
  assign d[0]     = sq;
  assign in_ready = rdy[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    dut_pipe_stage #(.W(RW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (v[gi]),
      .in_ready (rdy[gi]),
      .in_data  (d[gi]),
      .out_valid(v[gi+1]),
      .out_ready(rdy[gi+1]),
      .out_data (d[gi+1])
    );
  end

  logic          out_valid_reg;
  logic [RW-1:0] out_data_reg;
  logic [RW-1:0] res_next;

  assign rdy[STAGES] = !out_valid_reg || out_ready;
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;

`ifdef DUT_ACCUM_EN
  localparam logic [RW-1:0] SAT_MAX = {1'b0, {(RW-1){1'b1}}};

  logic [RW-1:0] acc_reg;
  logic [RW-1:0] acc_base;
  logic [RW:0]   sum;

  // Squares and the sum are never negative, so only the upper bound can be crossed.
  always_comb begin
    acc_base = (out_valid_reg && out_ready) ? out_data_reg : acc_reg;
    sum      = {1'b0, acc_base} + {1'b0, d[STAGES]};
    res_next = (sum > {1'b0, SAT_MAX}) ? SAT_MAX : sum[RW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_reg <= '0;
    else if (out_valid_reg && out_ready) acc_reg <= out_data_reg;
  end
`else
  always_comb begin
    res_next = d[STAGES];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (rdy[STAGES]) begin
      out_valid_reg <= v[STAGES];
      if (v[STAGES]) out_data_reg <= res_next;
    end
  end
endmodule

// File: tb/tb_dut_core.sv
// Self-checking bench for dut_core: queue-based reference model, randomized and directed scenarios.
module tb_dut_core;
  import dut_pkg::*;

  localparam int     STAGES = 2;
  localparam longint SAT    = 64'd2147483647;

  logic    clk = 1'b0;
  logic    rst;
  logic    in_valid;
  logic    in_ready;
  sample_t in_data;
  logic    out_valid;
  logic    out_ready;
  result_t out_data;

  int     tests_run;
  int     tests_failed;
  longint exp_q[$];
  longint got_q[$];
  longint model_acc;
  int     n_in;
  int     n_out;
  logic   last_acc;
  logic   last_emit;

  always #5 clk = ~clk;

  dut_core #(.DATAW(DATAW), .STAGES(STAGES)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  // Reference: each accepted sample yields its square (or the saturated running sum), in order.
  task automatic model_push(input int x);
    longint s;
    s = longint'(x) * longint'(x);
`ifdef DUT_ACCUM_EN
    model_acc = model_acc + s;
    if (model_acc > SAT) model_acc = SAT;
    exp_q.push_back(model_acc);
`else
    exp_q.push_back(s);
`endif
  endtask

  task automatic model_clear();
    exp_q.delete();
    got_q.delete();
    model_acc = 0;
    n_in  = 0;
    n_out = 0;
  endtask

  // One clock cycle: drive after the falling edge, observe before the next rising edge.
  task automatic step(input logic iv, input int id, input logic ordy);
    longint e;
    @(negedge clk);
    in_valid  = iv;
    in_data   = sample_t'(id);
    out_ready = ordy;
    #1;
    last_acc  = iv && in_ready;
    last_emit = out_valid && ordy;
    if (last_acc) begin
      model_push(id);
      n_in++;
    end
    if (last_emit) begin
      n_out++;
      got_q.push_back(longint'(out_data));
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_output got=%0d required=no output", out_data);
      end else begin
        e = exp_q.pop_front();
        if (longint'(out_data) !== e) begin
          tests_failed++;
          $display("FAIL output_value got=%0d required=%0d", out_data, e);
        end
      end
      $display("[TB] out %0d", out_data);
    end
  endtask

  task automatic drain(input int max_cycles);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      step(1'b0, 0, 1'b1);
      c++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout got=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%b/%0d required=0/0", out_valid, out_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready got=%b required=1", in_ready);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    int first;
    do_reset();
    step(1'b1, 3, 1'b1);
    tests_run++;
    if (!last_acc) begin
      tests_failed++;
      $display("FAIL single_accept got=0 required=1");
    end
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 0, 1'b1);
      if (last_emit && first == 0) first = i;
    end
    // Step i observes state after edge N+i-1, so latency STAGES shows up at step STAGES+1.
    tests_run++;
    if (first != STAGES + 1) begin
      tests_failed++;
      $display("FAIL single_latency got=%0d required=%0d", first - 1, STAGES);
    end
    tests_run++;
    if (n_out != 1 || got_q.size() != 1 || got_q[0] != 9) begin
      tests_failed++;
      $display("FAIL single_result got=%0d outputs required=1 output of 9", n_out);
    end
    $display("[TB] single sample 3 done");
  endtask

  task automatic test_back_to_back();
    int     vals[4];
    longint req[4];
    int     emit_steps[$];
    vals = '{-32768, 32767, -1, 0};
`ifdef DUT_ACCUM_EN
    req = '{64'd1073741824, 64'd2147418113, 64'd2147418114, 64'd2147418114};
`else
    req = '{64'd1073741824, 64'd1073676289, 64'd1, 64'd0};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], 1'b1);
      if (last_emit) emit_steps.push_back(i);
      tests_run++;
      if (!last_acc) begin
        tests_failed++;
        $display("FAIL b2b_in_ready got=0 required=1 at sample %0d", i);
      end
    end
    for (int i = 4; i < 12; i++) begin
      step(1'b0, 0, 1'b1);
      if (last_emit) emit_steps.push_back(i);
    end
    tests_run++;
    if (got_q.size() != 4 || emit_steps.size() != 4 || emit_steps[3] - emit_steps[0] != 3) begin
      tests_failed++;
      $display("FAIL b2b_rate got=%0d outputs required=4 on consecutive cycles", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_q[i] != req[i]) begin
          tests_failed++;
          $display("FAIL b2b_value got=%0d required=%0d", got_q[i], req[i]);
        end
      end
    end
    $display("[TB] back-to-back done");
  endtask

  task automatic test_backpressure();
    int     idx;
    int     cyc;
    logic   ordy;
    logic   saw_block;
    logic   have_held;
    result_t held;
    longint req;
    longint run;
    do_reset();
    idx = 1;
    cyc = 0;
    saw_block = 1'b0;
    have_held = 1'b0;
    held = '0;
    while ((idx <= 10 || exp_q.size() != 0) && cyc < 200) begin
      ordy = !(cyc >= 3 && cyc < 11);
      step(idx <= 10, idx, ordy);
      if (idx <= 10 && !in_ready) saw_block = 1'b1;
      if (last_acc) idx++;
      if (!ordy && out_valid) begin
        if (have_held) begin
          tests_run++;
          if (out_data !== held) begin
            tests_failed++;
            $display("FAIL stall_hold got=%0d required=%0d", out_data, held);
          end
        end
        held = out_data;
        have_held = 1'b1;
      end
      cyc++;
    end
    tests_run++;
    if (!saw_block || !have_held) begin
      tests_failed++;
      $display("FAIL stall_in_ready got=%b required=in_ready low during stall", saw_block);
    end
    tests_run++;
    if (got_q.size() != 10) begin
      tests_failed++;
      $display("FAIL stall_count got=%0d required=10", got_q.size());
    end else begin
      run = 0;
      for (int k = 1; k <= 10; k++) begin
`ifdef DUT_ACCUM_EN
        run = run + k * k;
        req = run;
`else
        req = k * k;
`endif
        tests_run++;
        if (got_q[k-1] != req) begin
          tests_failed++;
          $display("FAIL stall_value got=%0d required=%0d", got_q[k-1], req);
        end
      end
    end
    $display("[TB] backpressure done");
  endtask

  task automatic test_random();
    int left;
    int cyc;
    do_reset();
    left = 1000;
    cyc = 0;
    while (left > 0 && cyc < 20000) begin
      step(logic'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768,
           logic'($urandom_range(0, 1)));
      if (last_acc) left--;
      cyc++;
    end
    drain(50);
    tests_run++;
    if (n_in != 1000 || n_out != n_in) begin
      tests_failed++;
      $display("FAIL random_count got=%0d in/%0d out required=1000/1000", n_in, n_out);
    end
    $display("[TB] random %0d samples done", n_in);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    step(1'b1, 7, 1'b0);
    step(1'b1, 8, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_setup got=%b required=1", out_valid);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      tests_failed++;
      $display("FAIL midreset_async got=%b/%0d required=0/0", out_valid, out_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);
    tests_run++;
    if (n_out != 0) begin
      tests_failed++;
      $display("FAIL midreset_stale got=%0d required=0", n_out);
    end
    step(1'b1, 5, 1'b1);
    drain(20);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] != 25) begin
      tests_failed++;
      $display("FAIL midreset_next got=%0d outputs required=one of 25", got_q.size());
    end
    $display("[TB] reset mid-stream done");
  endtask

`ifdef DUT_ACCUM_EN
  task automatic test_accum();
    longint req[3];
    req = '{64'd4, 64'd13, 64'd29};
    do_reset();
    step(1'b1, 2, 1'b1);
    step(1'b1, 3, 1'b1);
    step(1'b1, 4, 1'b1);
    drain(20);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (got_q.size() != 3 || got_q[i] != req[i]) begin
        tests_failed++;
        $display("FAIL accum_value got=%0d required=%0d", (got_q.size() > i) ? got_q[i] : -1, req[i]);
      end
    end
    $display("[TB] accumulate done");
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, -32768, 1'b1);
    drain(20);
    tests_run++;
    if (got_q.size() != 4 || got_q[3] != SAT) begin
      tests_failed++;
      $display("FAIL accum_saturate got=%0d outputs required=last 2147483647", got_q.size());
    end
    $display("[TB] saturation done");
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
`ifdef DUT_ACCUM_EN
    test_accum();
    test_saturate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
